mux_scan: RTL and testbench

Parametrised, registered N-channel by W-bit multiplexer, the successor to the fixed 4x1 two-level mux built from 2x1 muxes. The block selects one of CHANNELS input words either from an external select (manual mode) or from an internal dwell-timed round-robin scanner (scan mode). It drives a registered output word, the active channel index, and a change strobe. It sits between a set of data sources (switch banks, counters, BCD digits) and a single downstream consumer such as a display driver.

---
 rtl/mux_scan.sv | 157 +++++++++++++++
 tb/tb_mux_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// ============================================================================
// Module      : mux_scan
// Description : Registered N-channel x W-bit multiplexer. The channel is
//               picked either from an external select (manual mode) or from
//               an internal dwell-timed round-robin scanner (scan mode).
//               Outputs the selected word, the active channel index and a
//               one-cycle strobe whenever the channel index changes.
// Options     : MUX_SCAN_CHAN_MASK_EN - adds chan_en[CHANNELS-1:0]; disabled
//               channels are skipped by the scanner and ignored by sel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 16,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
`ifdef MUX_SCAN_CHAN_MASK_EN
  input  logic [CHANNELS-1:0]       chan_en,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           chan,
  output logic                      valid
);

  // Dwell counter needs at least one bit even when DWELL is 1.
  localparam int            c_CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);
  // CHANNELS always fits in SELW+1 bits, so the range compare is exact.
  localparam logic [SELW:0] c_CHAN_LIM = (SELW + 1)'(CHANNELS);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [SELW-1:0]      r_chan;
  logic [SELW-1:0]      w_chan_nxt;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_valid;

  logic [CHANNELS-1:0]  w_en;
  logic                 w_sel_ok;
  logic [SELW-1:0]      w_adv_chan;
  logic                 w_adv_found;
  logic [WIDTH-1:0]     w_words [CHANNELS];

  // Per-channel enable mask; without the mask option every channel is live.
`ifdef MUX_SCAN_CHAN_MASK_EN
  assign w_en = chan_en;
`else
  assign w_en = {CHANNELS{1'b1}};
`endif

  // Unpack the flat input bus into one word per channel.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign w_words[k] = din[k*WIDTH +: WIDTH];
  end

  // A manual select is honoured only for an existing, enabled channel.
  always_comb begin
    w_sel_ok = 1'b0;
    if ({1'b0, sel} < c_CHAN_LIM) begin
      w_sel_ok = w_en[sel];
    end
  end

  // Find the next enabled channel after the current one in wrap order;
  // if none exists the scanner stays where it is.
  always_comb begin
    int idx;
    w_adv_chan  = r_chan;
    w_adv_found = 1'b0;
    for (int i = 1; i < CHANNELS; i++) begin
      idx = (int'(r_chan) + i) % CHANNELS;
      if (!w_adv_found && w_en[idx]) begin
        w_adv_found = 1'b1;
        w_adv_chan  = SELW'(idx);
      end
    end
  end

  // Next-state logic: mode changes take priority over hold and terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_chan_nxt  = r_chan;
    case (r_state)
      ST_MANUAL: begin
        w_cnt_nxt = '0;
        if (mode) begin
          // Scanning resumes from whatever channel is currently shown.
          w_state_nxt = ST_SCAN;
        end else if (w_sel_ok) begin
          w_chan_nxt = sel;
        end
      end
      ST_SCAN: begin
        if (!mode) begin
          w_state_nxt = ST_MANUAL;
          w_cnt_nxt   = '0;
          if (w_sel_ok) begin
            w_chan_nxt = sel;
          end
        end else if (hold) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt  = '0;
          w_chan_nxt = w_adv_chan;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_MANUAL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and output registers; dout follows live din of the
  // channel being loaded, and valid flags any change of channel index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_cnt   <= '0;
      r_chan  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chan  <= w_chan_nxt;
      r_dout  <= w_words[w_chan_nxt];
      r_valid <= (w_chan_nxt != r_chan);
    end
  end

  assign dout  = r_dout;
  assign chan  = r_chan;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// ============================================================================
// Module      : tb_mux_scan
// Description : Scoreboard bench for mux_scan (WIDTH=4, CHANNELS=4, DWELL=4,
//               channel k word = k+5). Stimulus pushes hand-computed
//               expectations; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;
`ifdef MUX_SCAN_CHAN_MASK_EN
  logic [3:0]  chan_en;
`endif
  logic [3:0]  dout;
  logic [1:0]  chan;
  logic        valid;

  typedef struct {
    logic [3:0] d;
    logic [1:0] c;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_err;

  mux_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .sel     (sel),
    .mode    (mode),
    .hold    (hold),
`ifdef MUX_SCAN_CHAN_MASK_EN
    .chan_en (chan_en),
`endif
    .dout    (dout),
    .chan    (chan),
    .valid   (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the following edge must yield.
  task automatic step(input logic m, input logic [1:0] s, input logic h,
                      input logic [1:0] ec, input logic [3:0] ed, input logic ev);
    exp_t e;
    mode = m;
    sel  = s;
    hold = h;
    e.d = ed;
    e.c = ec;
    e.v = ev;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation is consumed per clock edge while any are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout",  {4'h0, dout},  {4'h0, e.d});
        chk("chan",  {6'h0, chan},  {6'h0, e.c});
        chk("valid", {7'h0, valid}, {7'h0, e.v});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n = 1'b0;
    mode  = 1'b0;
    sel   = 2'd0;
    hold  = 1'b0;
    din   = {4'd8, 4'd7, 4'd6, 4'd5};
`ifdef MUX_SCAN_CHAN_MASK_EN
    chan_en = 4'b1111;
`endif
    #1;
    chk("rst_dout",  {4'h0, dout},  8'h00);
    chk("rst_chan",  {6'h0, chan},  8'h00);
    chk("rst_valid", {7'h0, valid}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select, repeated select, live din tracking
    step(0, 2, 0, 2, 4'd7, 1);
    step(0, 2, 0, 2, 4'd7, 0);
    din[11:8] = 4'hA;
    step(0, 2, 0, 2, 4'hA, 0);
    din[11:8] = 4'd7;
    step(0, 0, 0, 0, 4'd5, 1);

    // Scan rotation 0,1,2,3,0 with four cycles each
    step(1, 0, 0, 0, 4'd5, 0);
    repeat (3) step(1, 0, 0, 0, 4'd5, 0);
    step(1, 0, 0, 1, 4'd6, 1);
    repeat (3) step(1, 0, 0, 1, 4'd6, 0);
    step(1, 0, 0, 2, 4'd7, 1);
    repeat (3) step(1, 0, 0, 2, 4'd7, 0);
    step(1, 0, 0, 3, 4'd8, 1);
    repeat (3) step(1, 0, 0, 3, 4'd8, 0);
    step(1, 0, 0, 0, 4'd5, 1);

    // Reach count 3 on channel 0, then hold for ten cycles
    repeat (3) step(1, 0, 0, 0, 4'd5, 0);
    repeat (4) step(1, 0, 1, 0, 4'd5, 0);
    din[3:0] = 4'hC;
    step(1, 0, 1, 0, 4'hC, 0);
    din[3:0] = 4'd5;
    repeat (5) step(1, 0, 1, 0, 4'd5, 0);
    step(1, 0, 0, 1, 4'd6, 1);

    // Mode switch at chan=1, count=2 to manual sel=3, then back to scan
    repeat (2) step(1, 0, 0, 1, 4'd6, 0);
    step(0, 3, 0, 3, 4'd8, 1);
    step(1, 3, 0, 3, 4'd8, 0);
    repeat (3) step(1, 3, 0, 3, 4'd8, 0);
    step(1, 3, 0, 0, 4'd5, 1);

    // Mode change on a terminal-count edge: manual load wins over advance
    repeat (3) step(1, 0, 0, 0, 4'd5, 0);
    step(0, 2, 0, 2, 4'd7, 1);
    step(0, 2, 0, 2, 4'd7, 0);
    // hold has no effect in manual mode
    step(0, 1, 1, 1, 4'd6, 1);

    // Asynchronous reset in the middle of a scan
    step(1, 1, 0, 1, 4'd6, 0);
    step(1, 1, 0, 1, 4'd6, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout",  {4'h0, dout},  8'h00);
    chk("async_rst_chan",  {6'h0, chan},  8'h00);
    chk("async_rst_valid", {7'h0, valid}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_chan", {6'h0, chan}, 8'h00);
    chk("rst_held_dout", {4'h0, dout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_chan", {6'h0, chan}, 8'h00);
    step(1, 0, 0, 0, 4'd5, 0);
    step(1, 0, 0, 0, 4'd5, 0);

`ifdef MUX_SCAN_CHAN_MASK_EN
    // Mask 0101: scan visits 0,2,0,2
    chan_en = 4'b0101;
    step(0, 0, 0, 0, 4'd5, 0);
    step(1, 0, 0, 0, 4'd5, 0);
    repeat (3) step(1, 0, 0, 0, 4'd5, 0);
    step(1, 0, 0, 2, 4'd7, 1);
    repeat (3) step(1, 0, 0, 2, 4'd7, 0);
    step(1, 0, 0, 0, 4'd5, 1);
    repeat (3) step(1, 0, 0, 0, 4'd5, 0);
    step(1, 0, 0, 2, 4'd7, 1);
    // Manual select of a disabled channel is ignored
    step(0, 1, 0, 2, 4'd7, 0);
    step(0, 0, 0, 0, 4'd5, 1);
    // Only channel 0 enabled: scanner never moves
    chan_en = 4'b0001;
    step(1, 0, 0, 0, 4'd5, 0);
    repeat (8) step(1, 0, 0, 0, 4'd5, 0);
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
